// File: rtl/cp0_pkg.sv
// Shared constants for the P7 coprocessor-0: register numbers, SR/Cause field positions,
// exception codes and the handler entry address.
package cp0_pkg;

    localparam logic [4:0] RegCount   = 5'd9;
    localparam logic [4:0] RegCompare = 5'd11;
    localparam logic [4:0] RegSr      = 5'd12;
    localparam logic [4:0] RegCause   = 5'd13;
    localparam logic [4:0] RegEpc     = 5'd14;
    localparam logic [4:0] RegPrid    = 5'd15;

    localparam int unsigned SrImHi  = 15;
    localparam int unsigned SrImLo  = 10;
    localparam int unsigned SrExl   = 1;
    localparam int unsigned SrIe    = 0;

    localparam int unsigned CauseBd    = 31;
    localparam int unsigned CauseIpHi  = 15;
    localparam int unsigned CauseIpLo  = 10;
    localparam int unsigned CauseExcHi = 6;
    localparam int unsigned CauseExcLo = 2;

    typedef enum logic [4:0] {
        ExcInt  = 5'd0,
        ExcAdEL = 5'd4,
        ExcAdES = 5'd5,
        ExcRi   = 5'd10,
        ExcOv   = 5'd12
    } exc_code_e;

    localparam logic [31:0] HandlerEntry = 32'h0000_4180;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for cp0; only instantiated when CP0_TIMER_EN is defined.
// timer_pend is sticky until Compare is rewritten.
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_count,
    input  logic        we_compare,
    input  logic [31:0] din,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_pend
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            compare    <= '0;
            timer_pend <= 1'b0;
        end else begin
            count <= we_count ? din : count + 32'd1;
            if (we_compare) begin
                compare <= din;
            end
            // A Compare write acknowledges the timer, even on the matching cycle.
            if (we_compare) begin
                timer_pend <= 1'b0;
            end else if ((count == compare) && (compare != 32'd0)) begin
                timer_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0.sv
// Coprocessor-0 beside the M stage: SR/Cause/EPC/PRId, mtc0/mfc0 and IntReq generation.
// Define CP0_TIMER_EN to add Count(9)/Compare(11) and the timer interrupt on IP[15].
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h2020_1121
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [29:0] PC,
    input  logic        BD_in,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [29:0] EPC,
    output logic [31:0] DOut
);

    logic [5:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic [5:0]  ip_q;
    logic [4:0]  exc_q;
    logic [29:0] epc_q;

    logic [5:0]  ip_next;
    logic        int_pend;
    logic        exc_pend;
    logic        wr_sr;
    logic        wr_epc;

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_pend;
    logic        wr_count;
    logic        wr_compare;

    assign wr_count   = WE && (A2 == RegCount) && !IntReq;
    assign wr_compare = WE && (A2 == RegCompare) && !IntReq;

    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .we_count   (wr_count),
        .we_compare (wr_compare),
        .din        (DIn),
        .count      (count),
        .compare    (compare),
        .timer_pend (timer_pend)
    );

    assign ip_next = {HWInt[5] | timer_pend, HWInt[4:0]};
`else
    assign ip_next = HWInt;
`endif

    assign int_pend = (|(ip_next & im_q)) & ie_q & !exl_q;
    assign exc_pend = (ExcCodeIn != 5'd0) & !exl_q;
    assign IntReq   = int_pend | exc_pend;

    // An instruction that traps is squashed, so its mtc0 must not land.
    assign wr_sr  = WE && (A2 == RegSr) && !IntReq;
    assign wr_epc = WE && (A2 == RegEpc) && !IntReq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            ip_q <= ip_next;
            if (IntReq) begin
                exl_q <= 1'b1;
                bd_q  <= BD_in;
                exc_q <= int_pend ? 5'(ExcInt) : ExcCodeIn;
                epc_q <= BD_in ? PC - 30'd1 : PC;
            end else begin
                if (wr_sr) begin
                    im_q  <= DIn[SrImHi:SrImLo];
                    exl_q <= DIn[SrExl];
                    ie_q  <= DIn[SrIe];
                end else if (EXLClr) begin
                    exl_q <= 1'b0;
                end
                if (wr_epc) begin
                    epc_q <= DIn[31:2];
                end
            end
        end
    end

    assign EPC = epc_q;

    always_comb begin
        DOut = '0;
        case (A1)
            RegSr: begin
                DOut[SrImHi:SrImLo] = im_q;
                DOut[SrExl]         = exl_q;
                DOut[SrIe]          = ie_q;
            end
            RegCause: begin
                DOut[CauseBd]               = bd_q;
                DOut[CauseIpHi:CauseIpLo]   = ip_q;
                DOut[CauseExcHi:CauseExcLo] = exc_q;
            end
            RegEpc:     DOut = {epc_q, 2'b00};
            RegPrid:    DOut = PRID;
`ifdef CP0_TIMER_EN
            RegCount:   DOut = count;
            RegCompare: DOut = compare;
`endif
            default:    DOut = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0: interrupts, exceptions, eret, mtc0/mfc0 and reset.
// The timer section only runs when CP0_TIMER_EN is defined.
module tb_cp0;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [29:0] PC;
    logic        BD_in;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [29:0] EPC;
    logic [31:0] DOut;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cp0 dut (
        .clk       (clk),
        .reset     (reset),
        .A1        (A1),
        .A2        (A2),
        .DIn       (DIn),
        .WE        (WE),
        .PC        (PC),
        .BD_in     (BD_in),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .IntReq    (IntReq),
        .EPC       (EPC),
        .DOut      (DOut)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        A1 = a;
        #1;
        chk(tag, DOut, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        #1;
        chk(tag, {31'b0, IntReq}, {31'b0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; A1 = 5'd0; A2 = 5'd0; DIn = '0; WE = 1'b0; PC = '0;
        BD_in = 1'b0; ExcCodeIn = '0; HWInt = '0; EXLClr = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk_irq("reset_intreq", 1'b0);
        chk_reg("reset_sr", 5'd12, 32'h0);
        chk_reg("reset_cause", 5'd13, 32'h0);
        chk_reg("reset_epc", 5'd14, 32'h0);
        chk_reg("prid", 5'd15, 32'h2020_1121);
        chk_reg("unlisted_reg", 5'd3, 32'h0);

        // Enable IM[10] and IE, then raise HWInt[0].
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
        tick();
        WE = 1'b0; HWInt = 6'b000001; PC = 30'h100;
        chk_reg("sr_written", 5'd12, 32'h0000_0401);
        chk_irq("hw_irq_same_cycle", 1'b1);
        tick();
        chk_irq("irq_masked_by_exl", 1'b0);
        chk_reg("sr_exl_set", 5'd12, 32'h0000_0403);
        chk_reg("cause_after_irq", 5'd13, 32'h0000_0400);
        chk_reg("epc_after_irq", 5'd14, 32'h0000_0400);
        chk("epc_port", {2'b00, EPC}, 32'h0000_0100);
        EXLClr = 1'b1; HWInt = 6'b0;
        tick();
        EXLClr = 1'b0;
        chk_reg("eret_clears_exl", 5'd12, 32'h0000_0401);
        chk_reg("cause_ip_follows_hw", 5'd13, 32'h0000_0000);

        // AdEL in a delay slot.
        ExcCodeIn = 5'd4; BD_in = 1'b1; PC = 30'h0C01;
        chk_irq("exc_same_cycle", 1'b1);
        tick();
        ExcCodeIn = 5'd0; BD_in = 1'b0;
        chk_reg("epc_bd", 5'd14, 32'h0000_3000);
        chk_reg("cause_bd_adel", 5'd13, 32'h8000_0010);
        chk_reg("sr_exl_exc", 5'd12, 32'h0000_0403);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        chk_reg("eret_after_exc", 5'd12, 32'h0000_0401);

        // eret and a new exception together: the exception wins.
        EXLClr = 1'b1; ExcCodeIn = 5'd5; PC = 30'h0040;
        chk_irq("exc_with_eret", 1'b1);
        tick();
        EXLClr = 1'b0; ExcCodeIn = 5'd0;
        chk_reg("exl_stays_set", 5'd12, 32'h0000_0403);
        chk_reg("cause_ades", 5'd13, 32'h0000_0014);
        chk_reg("epc_no_bd", 5'd14, 32'h0000_0100);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;

        // Interrupt and Ov together, plus a squashed mtc0 EPC.
        HWInt = 6'b000001; ExcCodeIn = 5'd12; PC = 30'h2000;
        WE = 1'b1; A2 = 5'd14; DIn = 32'hFFFF_FFFC;
        chk_irq("irq_and_exc", 1'b1);
        tick();
        WE = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'b0;
        chk_reg("irq_beats_exc", 5'd13, 32'h0000_0400);
        chk_reg("mtc0_discarded", 5'd14, 32'h0000_8000);

        // Nested events are ignored while EXL is set.
        ExcCodeIn = 5'd10; HWInt = 6'h3F; PC = 30'h1234;
        chk_irq("nested_blocked", 1'b0);
        tick();
        ExcCodeIn = 5'd0;
        chk_reg("epc_unchanged", 5'd14, 32'h0000_8000);
        chk_reg("cause_ip_all", 5'd13, 32'h0000_FC00);

        WE = 1'b1; A2 = 5'd14; DIn = 32'h1234_5678;
        tick();
        A2 = 5'd13; DIn = 32'hFFFF_FFFF;
        tick();
        A2 = 5'd15;
        tick();
        A2 = 5'd9;
        tick();
        WE = 1'b0;
        chk_reg("mtc0_epc", 5'd14, 32'h1234_5678);
        chk_reg("cause_read_only", 5'd13, 32'h0000_FC00);
        chk_reg("prid_read_only", 5'd15, 32'h2020_1121);
`ifndef CP0_TIMER_EN
        chk_reg("count_absent", 5'd9, 32'h0);
`endif

        // Asynchronous reset mid-cycle with EXL=1.
        WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_EAF0;
        tick();
        WE = 1'b0;
        chk("epc_before_reset", {2'b00, EPC}, 32'h0000_3ABC);
        reset = 1'b1;
        chk_reg("async_reset_epc", 5'd14, 32'h0);
        chk_reg("async_reset_sr", 5'd12, 32'h0);
        chk_reg("async_reset_cause", 5'd13, 32'h0);
        chk_irq("async_reset_intreq", 1'b0);
        HWInt = 6'b0;
        tick();
        reset = 1'b0;

`ifdef CP0_TIMER_EN
        begin
            bit found = 1'b0;
            WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_8001;
            tick();
            A2 = 5'd11; DIn = 32'd5;
            tick();
            A2 = 5'd9; DIn = 32'd0;
            tick();
            WE = 1'b0;
            chk_reg("compare_read", 5'd11, 32'd5);
            for (int i = 0; i < 20; i++) begin
                #1;
                if (IntReq) begin
                    found = 1'b1;
                    break;
                end
                tick();
            end
            chk("timer_irq_seen", {31'b0, found}, 32'd1);
            tick();
            chk_reg("timer_ip15", 5'd13, 32'h0000_8000);
            WE = 1'b1; A2 = 5'd11; DIn = 32'd0;
            tick();
            WE = 1'b0;
            tick();
            chk_reg("timer_cleared", 5'd13, 32'h0000_0000);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
